// File: rtl/vote_pkg.sv
// Shared types and helpers for the majority-vote result buffer.
package vote_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ARGMAX  = 2'd1,
        WRITE   = 2'd2
    } vote_state_e;

    localparam int VOTE_WORD_W = 32;
    localparam int RR_MAX      = 32;

    // One-hot grant to the first requester at or after ptr, wrapping modulo n (n <= RR_MAX).
    function automatic logic [RR_MAX-1:0] rr_grant(input logic [RR_MAX-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned n = RR_MAX);
        logic [RR_MAX-1:0] grant;
        logic              found;
        int unsigned       idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && req[idx[4:0]]) begin
                grant[idx[4:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/vote_majority_buffer_ram.sv
// Simple dual-port result RAM: one write port, registered read-first read port.
module vote_result_ram #(
    parameter int DEPTH_BIT = 10,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [DEPTH_BIT-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [DEPTH_BIT-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_BIT];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Same-address read during a write sees the old word.
    always_ff @(posedge clk) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/vote_majority_buffer.sv
// Round-robin vote collector with per-sample argmax into a result RAM.
// VOTE_CONFIDENCE_EN: stores the winning vote count alongside the class.
module vote_majority_buffer
    import vote_pkg::*;
#(
    parameter int N_DTPS    = 5,
    parameter int RES_WIDTH = 16,
    parameter int N_CLASSES = 8,
    parameter int CLASS_BIT = $clog2(N_CLASSES),
    parameter int TREE_BIT  = 8,
    parameter int DEPTH_BIT = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          buffer_rst,
    input  logic [TREE_BIT-1:0]           n_trees,
    input  logic [N_DTPS-1:0]             res_vld,
    input  logic [N_DTPS*RES_WIDTH-1:0]   res_val,
    output logic [N_DTPS-1:0]             res_rdy,
    input  logic                          rd_en,
    input  logic [DEPTH_BIT-1:0]          rd_addr,
    output logic [VOTE_WORD_W-1:0]        rd_data,
    output logic [DEPTH_BIT:0]            sample_cnt,
    output logic                          busy,
    output logic                          full,
    output logic                          class_err
);

    localparam int PTR_W = (N_DTPS > 1) ? $clog2(N_DTPS) : 1;

    vote_state_e          state, state_nx;
    logic [TREE_BIT-1:0]  votes [N_CLASSES];
    logic [TREE_BIT-1:0]  tree_cnt;
    logic [PTR_W-1:0]     rr_ptr;
    logic [CLASS_BIT-1:0] scan_idx;
    logic [CLASS_BIT-1:0] best_cls;
    logic [TREE_BIT-1:0]  best_cnt;

    logic [RR_MAX-1:0]    grant_full;
    logic                 grant_unused;
    logic [PTR_W-1:0]     gnt_idx;
    logic [RES_WIDTH-1:0] gnt_val;
    logic                 xfer, cls_ok, last_vote, scan_last;
    logic [CLASS_BIT-1:0] cls;
    logic [PTR_W-1:0]     ptr_nx;
    logic [TREE_BIT-1:0]  n_eff_m1;
    logic                 ram_we;
    logic [VOTE_WORD_W-1:0] ram_wdata;

    assign full = sample_cnt[DEPTH_BIT];
    assign busy = (state != COLLECT) || (tree_cnt != '0);

    // Grant is held off while either reset is active so no transfer is silently dropped.
    assign grant_full   = rr_grant(RR_MAX'(res_vld), 32'(rr_ptr), N_DTPS);
    assign grant_unused = ^grant_full;
    assign res_rdy      = (state == COLLECT && !full && rst_n && !buffer_rst)
                          ? grant_full[N_DTPS-1:0] : '0;
    assign xfer         = |(res_vld & res_rdy);

    always_comb begin
        gnt_idx = '0;
        gnt_val = '0;
        for (int i = 0; i < N_DTPS; i++) begin
            if (grant_full[i]) begin
                gnt_idx = PTR_W'(i);
                gnt_val = res_val[i*RES_WIDTH +: RES_WIDTH];
            end
        end
    end

    // Any result value outside 0..N_CLASSES-1 is an invalid class, including stray upper bits.
    assign cls       = gnt_val[CLASS_BIT-1:0];
    assign cls_ok    = gnt_val < RES_WIDTH'(N_CLASSES);
    assign ptr_nx    = (gnt_idx == PTR_W'(N_DTPS-1)) ? '0 : gnt_idx + PTR_W'(1);
    assign n_eff_m1  = (n_trees == '0) ? '0 : n_trees - TREE_BIT'(1);
    assign last_vote = (tree_cnt == n_eff_m1);
    assign scan_last = (scan_idx == CLASS_BIT'(N_CLASSES-1));

    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (xfer && last_vote) state_nx = ARGMAX;
            ARGMAX:  if (scan_last)         state_nx = WRITE;
            WRITE:                          state_nx = COLLECT;
            default:                        state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || buffer_rst) begin
            state      <= COLLECT;
            tree_cnt   <= '0;
            rr_ptr     <= '0;
            scan_idx   <= '0;
            best_cls   <= '0;
            best_cnt   <= '0;
            sample_cnt <= '0;
            class_err  <= 1'b0;
            for (int c = 0; c < N_CLASSES; c++) votes[c] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        if (!cls_ok)                class_err  <= 1'b1;
                        else if (votes[cls] != '1)  votes[cls] <= votes[cls] + TREE_BIT'(1);
                        tree_cnt <= last_vote ? '0 : tree_cnt + TREE_BIT'(1);
                        rr_ptr   <= ptr_nx;
                    end
                end
                ARGMAX: begin
                    if (votes[scan_idx] > best_cnt) begin
                        best_cnt <= votes[scan_idx];
                        best_cls <= scan_idx;
                    end
                    scan_idx <= scan_last ? '0 : scan_idx + CLASS_BIT'(1);
                end
                WRITE: begin
                    for (int c = 0; c < N_CLASSES; c++) votes[c] <= '0;
                    best_cls   <= '0;
                    best_cnt   <= '0;
                    sample_cnt <= sample_cnt + (DEPTH_BIT+1)'(1);
                end
                default: ;
            endcase
        end
    end

    assign ram_we = (state == WRITE) && rst_n && !buffer_rst;

`ifdef VOTE_CONFIDENCE_EN
    assign ram_wdata = (VOTE_WORD_W'(best_cnt) << CLASS_BIT) | VOTE_WORD_W'(best_cls);
`else
    assign ram_wdata = VOTE_WORD_W'(best_cls);
`endif

    vote_result_ram #(
        .DEPTH_BIT (DEPTH_BIT),
        .WIDTH     (VOTE_WORD_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (sample_cnt[DEPTH_BIT-1:0]),
        .wdata (ram_wdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
